// File: rtl/systolic_drain_pkg.sv
// systolic_drain_pkg: shared sizing parameters and drain FSM state encoding.
package systolic_drain_pkg;
    localparam int ARRAY_SIZE = 32;
    localparam int ACC_WIDTH  = 69;
    localparam int OUT_WIDTH  = 32;
    localparam int ADDR_WIDTH = 10;
    typedef enum logic [1:0] {IDLE, SELECT, EMIT, DONE} state_e;
endpackage

// File: rtl/sat_narrow.sv
// sat_narrow: signed saturation of one accumulator lane down to a result word.
module sat_narrow #(
    parameter int ACC_WIDTH = systolic_drain_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH = systolic_drain_pkg::OUT_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] in_i,
    output logic [OUT_WIDTH-1:0] out_o,
    output logic                 sat_o
);
    logic [ACC_WIDTH-OUT_WIDTH:0] hi;
    // Value fits when the discarded bits plus the kept sign bit are all equal
    assign hi    = in_i[ACC_WIDTH-1:OUT_WIDTH-1];
    assign sat_o = !((&hi) || !(|hi));
    assign out_o = !sat_o ? in_i[OUT_WIDTH-1:0] :
                   in_i[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: drains an NxN result matrix diagonal by diagonal from the array
// into a row-major result SRAM, saturating each word and counting saturations.
module systolic_drain #(
    parameter int ARRAY_SIZE = systolic_drain_pkg::ARRAY_SIZE,
    parameter int ACC_WIDTH  = systolic_drain_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH  = systolic_drain_pkg::OUT_WIDTH,
    parameter int ADDR_WIDTH = systolic_drain_pkg::ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0] mul_outcome,
    output logic [5:0]                      matrix_index,
    output logic                            wr_valid,
    input  logic                            wr_ready,
    output logic [ADDR_WIDTH-1:0]           wr_addr,
    output logic [OUT_WIDTH-1:0]            wr_data,
    output logic                            busy,
    output logic                            done,
    output logic [10:0]                     sat_count
);
    import systolic_drain_pkg::*;

    localparam int KW = ARRAY_SIZE > 1 ? $clog2(ARRAY_SIZE) : 1;
    localparam logic [KW-1:0] LAST = KW'(ARRAY_SIZE - 1);

    state_e                          state_q;
    logic [KW-1:0]                   k_q, r_q, col;
    logic [10:0]                     sat_q;
    logic [ARRAY_SIZE*ACC_WIDTH-1:0] cap_q;
    logic [ACC_WIDTH-1:0]            lane;
    logic [OUT_WIDTH-1:0]            narrow;
    logic                            sat;

    assign lane = cap_q[r_q*ACC_WIDTH +: ACC_WIDTH];
    // Column of row r on diagonal k is (k - r) mod N, kept correct for non power-of-two N
    assign col  = (k_q >= r_q) ? k_q - r_q : k_q + KW'(ARRAY_SIZE) - r_q;

    sat_narrow #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_sat (
        .in_i (lane),
        .out_o(narrow),
        .sat_o(sat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            r_q     <= '0;
            sat_q   <= '0;
            cap_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= SELECT;
                    k_q     <= '0;
                    sat_q   <= '0;
                end
                SELECT: begin
                    cap_q   <= mul_outcome;
                    r_q     <= '0;
                    state_q <= EMIT;
                end
                EMIT: if (wr_ready) begin
                    sat_q <= sat_q + {10'b0, sat};
                    if (r_q != LAST) r_q <= r_q + 1'b1;
                    else if (k_q != LAST) begin
                        k_q     <= k_q + 1'b1;
                        state_q <= SELECT;
                    end else state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_valid     = state_q == EMIT;
    assign wr_addr      = wr_valid ? ADDR_WIDTH'(r_q) * ADDR_WIDTH'(ARRAY_SIZE) + ADDR_WIDTH'(col) : '0;
    assign wr_data      = wr_valid ? narrow : '0;
    assign busy         = state_q == SELECT || state_q == EMIT;
    assign done         = state_q == DONE;
    assign matrix_index = state_q == SELECT ? 6'(k_q) : 6'd0;
    assign sat_count    = sat_q;
endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: array/SRAM model around systolic_drain with table vectors,
// randomized data and backpressure, reset and start-while-busy sequences.
module tb_systolic_drain;
    localparam int N = 32;
    localparam int W = 69;

    logic           clk = 0, rst_n = 0, start = 0, wr_ready = 0;
    logic [N*W-1:0] mul_outcome;
    logic [5:0]     matrix_index;
    logic           wr_valid, busy, done;
    logic [9:0]     wr_addr;
    logic [31:0]    wr_data;
    logic [10:0]    sat_count;

    systolic_drain dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mul_outcome(mul_outcome),
        .matrix_index(matrix_index), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    logic signed [W-1:0] cm [N][N];
    // Array model: lane i presents element (i, (index - i) mod N)
    always_comb for (int i = 0; i < N; i++) mul_outcome[i*W +: W] = cm[i][(int'(matrix_index) - i + N) % N];

    int          nchk = 0, nerr = 0, cyc = 0, nwr = 0, ndone = 0, done_cyc = 0, t0 = 0, exp_sat = 0;
    logic [31:0] mem [N*N];
    logic [31:0] expm [N*N];
    int          wcnt [N*N];
    logic [9:0]  wlog [N*N+8];
    logic [9:0]  p_addr;
    logic [31:0] p_data;
    bit          stall_p = 0;

    typedef struct { logic signed [W-1:0] val; logic [31:0] exp; logic sat; } vec_t;
    vec_t vt [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_sat(input logic signed [W-1:0] v);
        return v > 69'sd2147483647 || v < -69'sd2147483648;
    endfunction

    function automatic logic [31:0] sat_ref(input logic signed [W-1:0] v);
        if (v > 69'sd2147483647) return 32'h7fffffff;
        if (v < -69'sd2147483648) return 32'h80000000;
        return v[31:0];
    endfunction

    task automatic fill_identity();
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) cm[i][j] = W'(i*N + j);
    endtask

    task automatic fill_random();
        logic signed [31:0] s;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            case ($urandom_range(3))
                0: begin s = $urandom; cm[i][j] = s; end
                1: cm[i][j] = W'({$urandom, $urandom, $urandom});
                2: cm[i][j] = 69'sd2147483646 + W'($urandom_range(3));
                default: cm[i][j] = -69'sd2147483650 + W'($urandom_range(3));
            endcase
        end
    endtask

    task automatic model();
        exp_sat = 0;
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) begin
            expm[i*N+j] = sat_ref(cm[i][j]);
            if (is_sat(cm[i][j])) exp_sat++;
        end
    endtask

    task automatic clear_log();
        nwr = 0;
        ndone = 0;
        done_cyc = -1;
        for (int a = 0; a < N*N; a++) begin
            wcnt[a] = 0;
            mem[a] = 32'hdeadbeef;
        end
    endtask

    task automatic run_drain(input int pct, input bit poke);
        clear_log();
        @(posedge clk); #1;
        start = 1;
        t0 = cyc;
        wr_ready = $urandom_range(99) < pct;
        @(posedge clk); #1;
        start = 0;
        for (int t = 0; t < 6000 && ndone == 0; t++) begin
            wr_ready = $urandom_range(99) < pct;
            start = poke && (nwr == 5 || nwr == 500);
            @(posedge clk); #1;
        end
        start = 0;
        chk("drain_finished", ndone > 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string tag);
        for (int a = 0; a < N*N; a++) begin
            chk($sformatf("%s_data[%0d]", tag, a), mem[a], expm[a]);
            chk($sformatf("%s_writes[%0d]", tag, a), wcnt[a], 1);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SRAM-side monitor, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (!rst_n) stall_p = 0;
        else begin
            if (stall_p) begin
                chk("stall_valid", wr_valid, 1);
                chk("stall_addr", wr_addr, p_addr);
                chk("stall_data", wr_data, p_data);
            end
            if (wr_valid && wr_ready) begin
                if (nwr < N*N+8) wlog[nwr] = wr_addr;
                nwr++;
                mem[wr_addr] = wr_data;
                wcnt[wr_addr]++;
            end
            stall_p = wr_valid && !wr_ready;
            p_addr = wr_addr;
            p_data = wr_data;
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        vt[0] = '{69'sd2147483647, 32'h7fffffff, 1'b0};
        vt[1] = '{69'sd2147483648, 32'h7fffffff, 1'b1};
        vt[2] = '{-69'sd2147483648, 32'h80000000, 1'b0};
        vt[3] = '{-69'sd2147483649, 32'h80000000, 1'b1};
        vt[4] = '{-69'sd1, 32'hffffffff, 1'b0};
        vt[5] = '{69'sd4294967296, 32'h7fffffff, 1'b1};
        vt[6] = '{{1'b0, {68{1'b1}}}, 32'h7fffffff, 1'b1};
        vt[7] = '{{1'b1, {68{1'b0}}}, 32'h80000000, 1'b1};

        fill_identity();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_matrix_index", matrix_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat_count", sat_count, 0);
        rst_n = 1;

        model();
        run_drain(100, 0);
        check_mem("ident");
        chk("ident_done_latency", done_cyc - t0, 1057);
        chk("ident_done_pulses", ndone, 1);
        chk("ident_total_writes", nwr, N*N);
        chk("ident_sat_count", sat_count, 0);
        chk("ident_busy_after", busy, 0);
        chk("ident_index_idle", matrix_index, 0);
        for (int idx = 0; idx < N*N; idx++)
            chk($sformatf("order[%0d]", idx), wlog[idx], (idx % N)*N + ((idx / N) - (idx % N) + N) % N);
        chk("addr_k3_r5", wlog[3*N+5], 190);

        fill_identity();
        cm[0][0] = 69'sd1 << 40;
        cm[1][1] = -(69'sd1 << 40);
        model();
        run_drain(100, 0);
        check_mem("sat");
        chk("sat_addr0", mem[0], 32'h7fffffff);
        chk("sat_addr33", mem[33], 32'h80000000);
        chk("sat_count2", sat_count, 2);

        for (int v = 0; v < 8; v++) begin
            fill_identity();
            cm[2][7] = vt[v].val;
            run_drain(100, 0);
            chk($sformatf("vec%0d_data", v), mem[2*N+7], vt[v].exp);
            chk($sformatf("vec%0d_sat_count", v), sat_count, 11'(vt[v].sat));
            chk($sformatf("vec%0d_neighbor", v), mem[2*N+8], 2*N+8);
        end

        fill_identity();
        model();
        run_drain(50, 0);
        check_mem("bp");
        chk("bp_done_pulses", ndone, 1);

        for (int n = 0; n < 2; n++) begin
            fill_random();
            model();
            run_drain(50, 0);
            check_mem($sformatf("rnd%0d", n));
            chk($sformatf("rnd%0d_sat_count", n), sat_count, exp_sat);
        end

        fill_identity();
        model();
        clear_log();
        @(posedge clk); #1;
        start = 1;
        wr_ready = 1;
        @(posedge clk); #1;
        start = 0;
        for (int t = 0; t < 400 && nwr < 100; t++) begin
            @(posedge clk); #1;
        end
        chk("mid_reached_100", nwr, 100);
        wr_ready = 0;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("mid_wr_valid", wr_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_sat_count", sat_count, 0);
        wr_ready = 1;
        repeat (40) @(posedge clk);
        #1;
        chk("mid_no_done", ndone, 0);
        chk("mid_no_writes", nwr, 100);
        chk("mid_still_idle", busy, 0);
        run_drain(100, 0);
        check_mem("after_rst");
        chk("after_rst_done_pulses", ndone, 1);

        run_drain(100, 1);
        chk("poke_total_writes", nwr, N*N);
        chk("poke_done_pulses", ndone, 1);
        chk("poke_done_latency", done_cyc - t0, 1057);
        check_mem("poke");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 Parameter ARRAY_SIZE, default 32, array dimension N.
REQ-002 Parameter ACC_WIDTH, default 69, width of one accumulator lane.
REQ-003 Parameter OUT_WIDTH, default 32, width of one result word written to result SRAM.
REQ-004 Parameter ADDR_WIDTH, default 10, result SRAM word address width (log2(N*N)).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  one-cycle request to drain the full NxN result matrix.
REQ-008 mul_outcome  input  N*ACC_WIDTH  signed lanes from the array; lane i = row i, combinational in matrix_index.
REQ-009 matrix_index  output  6  diagonal selector driven to the array.
REQ-010 wr_valid  output  1  result word valid.
REQ-011 wr_ready  input  1  result SRAM accepts the word this cycle.
REQ-012 wr_addr  output  ADDR_WIDTH  row-major address row*N+col.
REQ-013 wr_data  output  OUT_WIDTH  saturated signed result.
REQ-014 busy  output  1  high from the cycle after an accepted start until done.
REQ-015 done  output  1  one-cycle pulse after the last word is accepted.
REQ-016 sat_count  output  11  number of saturated words in the current/last drain.

Function
REQ-017 FSM states IDLE, SELECT, EMIT, DONE; IDLE on reset.
REQ-018 IDLE: start=1 -> SELECT, diagonal counter k=0, sat_count cleared; start ignored in all other states.
REQ-019 SELECT: matrix_index=k; at the clock edge, all N lanes of mul_outcome are registered into a capture buffer, lane counter r=0 -> EMIT.
REQ-020 Lane i captured for diagonal k is element (row i, col (k-i) mod N).
REQ-021 EMIT: wr_valid=1, wr_addr=r*N+((k-r) mod N), wr_data=sat(capture[r]).
REQ-022 wr_addr, wr_data and wr_valid stay stable while wr_valid=1 and wr_ready=0.
REQ-023 On wr_valid&&wr_ready: if r<N-1, r increments; else if k<N-1, k increments -> SELECT; else -> DONE.
REQ-024 DONE: done=1 for exactly one cycle -> IDLE; busy=0 in IDLE and DONE.
REQ-025 Saturation: value > 2^(OUT_WIDTH-1)-1 yields 0x7FFFFFFF; value < -2^(OUT_WIDTH-1) yields 0x80000000; otherwise the low OUT_WIDTH bits, sign preserved.
REQ-026 sat_count increments by 1 on each accepted word that was saturated; it holds its value after DONE until the next start.
REQ-027 matrix_index is 0 outside SELECT.
REQ-028 Throughput with wr_ready held at 1: N*(N+1) cycles from the first SELECT to the last accept; done rises on the following cycle.
REQ-029 Each of the N*N addresses is written exactly once per drain.

Reset
REQ-030 With rst_n=0 at an edge: state=IDLE, wr_valid=0, wr_addr=0, wr_data=0, matrix_index=0, busy=0, done=0, sat_count=0, k=0, r=0.
REQ-031 Reset during SELECT/EMIT aborts the drain with no further writes and no done pulse.

Structure
REQ-032 Shared package holds ARRAY_SIZE, ACC_WIDTH, OUT_WIDTH, ADDR_WIDTH and the FSM state encoding.
REQ-033 One sub-module, sat_narrow: combinational saturation from ACC_WIDTH to OUT_WIDTH with a saturated flag.
REQ-034 Capture buffer size is N*ACC_WIDTH flops; no other data storage.

Verification
REQ-035 Identity test: array model with C[i][j]=i*32+j, wr_ready=1 -> 1024 writes with mem[a]==a, done on cycle 1057 after start, sat_count=0.
REQ-036 Saturation test: C[0][0]=2^40, C[1][1]=-2^40 -> wr_data 0x7FFFFFFF at addr 0 and 0x80000000 at addr 33; sat_count=2.
REQ-037 Backpressure test: wr_ready random at 50% -> wr_addr/wr_data stable while stalled, final memory identical to the identity test.
REQ-038 Mid-drain reset: rst_n=0 for 1 cycle at word 100 -> wr_valid=0, busy=0, no done pulse; a new start gives a complete, correct drain.
REQ-039 Start while busy: pulse start at words 5 and 500 -> ignored, exactly 1024 writes, one done pulse.
REQ-040 Address coverage: diagonal k=3, row 5 -> written to address 5*32+30=190.
